// File: rtl/intr_responder.sv
// intr_responder: interrupt entry (SRR save, MSR mask, redirect, ack) and rfi return.
// Optional ESR at SPR 62 enabled by defining INTR_ESR_EN.
module intr_responder #(
    parameter int EXCEP_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [EXCEP_W-1:0] excepCode,
    input  logic [0:31]        intrEntryAddr,
    input  logic [0:31]        PC,
    input  logic [0:31]        MSR,
    input  logic               hold,
    input  logic               rfi,
    input  logic [9:0]         spr_addr,
    input  logic               spr_wr,
    input  logic [0:31]        spr_wd,
`ifdef INTR_ESR_EN
    input  logic [2:0]         progErrCode,
    input  logic               dsiStore,
`endif
    output logic [0:31]        spr_rd,
    output logic               MSR_wr,
    output logic [0:31]        MSR_wd,
    output logic               pc_wr,
    output logic [0:31]        pc_wd,
    output logic               flush,
    output logic               ack,
    output logic [0:31]        SRR0,
    output logic [0:31]        SRR1
);
    typedef enum logic [2:0] {IDLE, SAVE, REDIR, ACK, DROP, RFI} state_t;
    // EE, PR, FP, IS, DS cleared on entry
    localparam logic [0:31] MSR_CLR = 32'h0000_E030;
    state_t      state, next;
    logic [3:0]  code_q;
    logic [0:31] addr_q, pc_q, msr_q, save_pc;
    logic        take;
    assign take = excepCode != '0 && excepCode <= EXCEP_W'(8) && !hold;
    assign save_pc = (code_q == 4'd3 || code_q == 4'd4 || code_q == 4'd6) ? pc_q + 32'd4 : pc_q;
`ifdef INTR_ESR_EN
    logic [0:31] esr;
    always_ff @(posedge clk)
        if (rst) esr <= '0;
        else if (state == SAVE)
            esr <= (code_q == 4'd5) ? {4'b0, progErrCode, 25'b0} :
                   (code_q == 4'd1) ? {8'b0, dsiStore, 23'b0} : '0;
        else if (spr_wr && spr_addr == 10'd62) esr <= spr_wd;
    assign spr_rd = (spr_addr == 10'd26) ? SRR0 : (spr_addr == 10'd27) ? SRR1 :
                    (spr_addr == 10'd62) ? esr : '0;
`else
    assign spr_rd = (spr_addr == 10'd26) ? SRR0 : (spr_addr == 10'd27) ? SRR1 : '0;
`endif
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            SRR0   <= '0;
            SRR1   <= '0;
            code_q <= '0;
            addr_q <= '0;
            pc_q   <= '0;
            msr_q  <= '0;
        end else begin
            state <= next;
            if (state == IDLE && take) begin
                code_q <= 4'(excepCode);
                addr_q <= intrEntryAddr;
                pc_q   <= PC;
                msr_q  <= MSR;
            end
            if (state == SAVE) SRR0 <= save_pc;
            else if (spr_wr && spr_addr == 10'd26) SRR0 <= spr_wd;
            if (state == SAVE) SRR1 <= msr_q;
            else if (spr_wr && spr_addr == 10'd27) SRR1 <= spr_wd;
        end
    end
    always_comb begin
        next   = state;
        MSR_wr = 1'b0;
        MSR_wd = '0;
        pc_wr  = 1'b0;
        pc_wd  = '0;
        flush  = 1'b0;
        ack    = 1'b0;
        case (state)
            IDLE:  next = take ? SAVE : (rfi && !hold) ? RFI : IDLE;
            SAVE: begin
                MSR_wr = 1'b1;
                MSR_wd = msr_q & ~MSR_CLR;
                next   = REDIR;
            end
            REDIR: begin
                pc_wr = 1'b1;
                flush = 1'b1;
                pc_wd = addr_q;
                next  = ACK;
            end
            ACK: begin
                ack  = 1'b1;
                next = DROP;
            end
            DROP:  next = (excepCode == '0) ? IDLE : DROP;
            RFI: begin
                pc_wr  = 1'b1;
                flush  = 1'b1;
                pc_wd  = SRR0;
                MSR_wr = 1'b1;
                MSR_wd = SRR1;
                next   = IDLE;
            end
            default: next = IDLE;
        endcase
    end
endmodule
